// File: rtl/qdec.sv
// qdec: quadrature encoder front-end (synchroniser, glitch filter, phase decoder).
// Define QDEC_INDEX_EN to add the z_in index channel and the idx strobe.
module qdec #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3,
  parameter string       RESOLUTION  = "X4"
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       sclr,
  input  logic       a_in,
  input  logic       b_in,
`ifdef QDEC_INDEX_EN
  input  logic       z_in,
  output logic       idx,
`endif
  output logic       ena,
  output logic       dir,
  output logic       err,
  output logic       err_sticky,
  output logic [1:0] ab_q
);

`ifdef QDEC_INDEX_EN
  localparam int unsigned NCH = 3;
`else
  localparam int unsigned NCH = 2;
`endif
  localparam int unsigned CW     = $clog2(FILT_LEN + 1);
  localparam bit          RES_X1 = (RESOLUTION == "X1");
  localparam bit          RES_X2 = (RESOLUTION == "X2");

  typedef enum logic {S_INIT, S_RUN} state_t;

  // Channel order: [0]=B, [1]=A, [2]=Z (index build only).
  logic [NCH-1:0]                  raw_c;
  logic [NCH-1:0][SYNC_STAGES-1:0] sync_r;
  logic [NCH-1:0][CW-1:0]          cnt_r;
  logic [NCH-1:0]                  filt_r;
  logic                            quiet_c;
  logic [1:0]                      ab_c;

  state_t     state;
  logic       quiet_q;
  logic [1:0] prev_ab;
  logic       ena_p, dir_p, err_p;
  logic       step_fwd_c, step_rev_c, step_bad_c, qual_c;

`ifdef QDEC_INDEX_EN
  assign raw_c = {z_in, a_in, b_in};
`else
  assign raw_c = {a_in, b_in};
`endif

  assign ab_c = filt_r[1:0];
  assign ab_q = ab_c;

  // Per-channel synchroniser chain and persistence filter.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      sync_r <= '0;
      cnt_r  <= '0;
      filt_r <= '0;
    end else if (sclr) begin
      sync_r <= '0;
      cnt_r  <= '0;
      filt_r <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], raw_c[i]};
        if (sync_r[i][SYNC_STAGES-1] == filt_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CW'(FILT_LEN - 1)) begin
          filt_r[i] <= sync_r[i][SYNC_STAGES-1];
          cnt_r[i]  <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
      end
    end
  end

  // Whole chain must agree with the filtered value, so a level already
  // present at reset release is absorbed before the decoder arms.
  always_comb begin
    quiet_c = 1'b1;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (cnt_r[i] != '0 || sync_r[i] != {SYNC_STAGES{filt_r[i]}}) quiet_c = 1'b0;
    end
  end

  // Step classification of filtered AB against the last accepted state.
  always_comb begin
    step_fwd_c = 1'b0;
    step_rev_c = 1'b0;
    step_bad_c = 1'b0;
    case ({prev_ab, ab_c})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_fwd_c = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_rev_c = 1'b1;
      4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: step_bad_c = 1'b1;
      default: ;
    endcase
    if (RES_X1)
      qual_c = (prev_ab == 2'b00 && ab_c == 2'b10) || (prev_ab == 2'b10 && ab_c == 2'b00);
    else if (RES_X2)
      qual_c = (step_fwd_c | step_rev_c) & (prev_ab[1] ^ ab_c[1]);
    else
      qual_c = step_fwd_c | step_rev_c;
  end

  // Decoder FSM with a one-stage output pipeline.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state      <= S_INIT;
      quiet_q    <= 1'b0;
      prev_ab    <= 2'b00;
      ena_p      <= 1'b0;
      dir_p      <= 1'b1;
      err_p      <= 1'b0;
      ena        <= 1'b0;
      dir        <= 1'b1;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else if (sclr) begin
      state      <= S_INIT;
      quiet_q    <= 1'b0;
      prev_ab    <= 2'b00;
      ena_p      <= 1'b0;
      dir_p      <= 1'b1;
      err_p      <= 1'b0;
      ena        <= 1'b0;
      dir        <= 1'b1;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      ena   <= ena_p;
      err   <= err_p;
      ena_p <= 1'b0;
      err_p <= 1'b0;
      if (ena_p) dir <= dir_p;
      if (err_p) err_sticky <= 1'b1;
      case (state)
        S_INIT: begin
          quiet_q <= quiet_c;
          if (quiet_c && quiet_q) begin
            prev_ab <= ab_c;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          prev_ab <= ab_c;
          ena_p   <= qual_c;
          dir_p   <= step_fwd_c;
          err_p   <= step_bad_c;
        end
        default: state <= S_INIT;
      endcase
    end
  end

`ifdef QDEC_INDEX_EN
  logic z_prev, idx_p;

  // Index strobe on filtered Z rising edge, same latency as ena.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      z_prev <= 1'b0;
      idx_p  <= 1'b0;
      idx    <= 1'b0;
    end else if (sclr) begin
      z_prev <= 1'b0;
      idx_p  <= 1'b0;
      idx    <= 1'b0;
    end else begin
      z_prev <= filt_r[2];
      idx_p  <= (state == S_RUN) && filt_r[2] && !z_prev;
      idx    <= idx_p;
    end
  end
`endif

endmodule

// File: tb/tb_qdec.sv
// tb_qdec: randomized and directed checks of qdec (X4/X2/X1 instances side by side)
// against a behavioural model of filtering and quadrature decoding.
`timescale 1ns/1ps
module tb_qdec;
  localparam int SYNC = 2;
  localparam int FLEN = 3;

  typedef struct packed { logic [2:0] ena; logic fwd; logic err; } ev_t;

  logic       clk = 1'b0;
  logic       aclr, sclr, a_in, b_in;
  logic [2:0] ena_v, dir_v, err_v, es_v;
  logic [1:0] ab_v [3];
`ifdef QDEC_INDEX_EN
  logic       z_in;
  logic [2:0] idx_v;
`endif

  always #5 clk = ~clk;

  qdec #(.SYNC_STAGES(SYNC), .FILT_LEN(FLEN), .RESOLUTION("X4")) u_x4 (
    .clk(clk), .aclr(aclr), .sclr(sclr), .a_in(a_in), .b_in(b_in),
`ifdef QDEC_INDEX_EN
    .z_in(z_in), .idx(idx_v[0]),
`endif
    .ena(ena_v[0]), .dir(dir_v[0]), .err(err_v[0]), .err_sticky(es_v[0]), .ab_q(ab_v[0]));

  qdec #(.SYNC_STAGES(SYNC), .FILT_LEN(FLEN), .RESOLUTION("X2")) u_x2 (
    .clk(clk), .aclr(aclr), .sclr(sclr), .a_in(a_in), .b_in(b_in),
`ifdef QDEC_INDEX_EN
    .z_in(z_in), .idx(idx_v[1]),
`endif
    .ena(ena_v[1]), .dir(dir_v[1]), .err(err_v[1]), .err_sticky(es_v[1]), .ab_q(ab_v[1]));

  qdec #(.SYNC_STAGES(SYNC), .FILT_LEN(FLEN), .RESOLUTION("X1")) u_x1 (
    .clk(clk), .aclr(aclr), .sclr(sclr), .a_in(a_in), .b_in(b_in),
`ifdef QDEC_INDEX_EN
    .z_in(z_in), .idx(idx_v[2]),
`endif
    .ena(ena_v[2]), .dir(dir_v[2]), .err(err_v[2]), .err_sticky(es_v[2]), .ab_q(ab_v[2]));

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         model_on = 1'b0;
  logic [1:0] rh [64];
  logic [1:0] m_filt = 2'b00;
  ev_t        d1 = '0, d2 = '0;
  logic [2:0] m_dir = 3'b111;
  logic       m_sticky = 1'b0;
  int         n_ena [3];
  int         n_err, n_idx, first_ena;
  string      nm [3] = '{"x4", "x2", "x1"};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Position on the forward cycle 00->10->11->01.
  function automatic int pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ab_of(input int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic bit qual(input int r, input logic [1:0] o, input logic [1:0] n);
    case (r)
      0:       return 1'b1;
      1:       return o[1] != n[1];
      default: return (o == 2'b00 && n == 2'b10) || (o == 2'b10 && n == 2'b00);
    endcase
  endfunction

  // One clock: record the sampled inputs, advance the model, compare #1 later.
  task automatic tick();
    ev_t        ev, exp_ev;
    logic [1:0] old, s;
    bit         all_diff;
    int         dp;
    @(posedge clk);
    rh[cyc % 64] = {a_in, b_in};
    exp_ev = '0;
    if (model_on) begin
      old = m_filt;
      for (int c = 0; c < 2; c++) begin
        all_diff = 1'b1;
        for (int j = 0; j < FLEN; j++) begin
          s = rh[(cyc + 64 - SYNC - j) % 64];
          if (s[c] == old[c]) all_diff = 1'b0;
        end
        if (all_diff) m_filt[c] = ~old[c];
      end
      exp_ev = d2;
      d2 = d1;
      ev = '0;
      if (m_filt != old) begin
        dp = (pos(m_filt) - pos(old)) & 3;
        if (dp == 2) ev.err = 1'b1;
        else begin
          ev.fwd = (dp == 1);
          for (int r = 0; r < 3; r++) ev.ena[r] = qual(r, old, m_filt);
        end
      end
      d1 = ev;
      for (int r = 0; r < 3; r++) if (exp_ev.ena[r]) m_dir[r] = exp_ev.fwd;
      if (exp_ev.err) m_sticky = 1'b1;
    end
    #1;
    if (model_on) begin
      for (int r = 0; r < 3; r++) begin
        chk({"ena_", nm[r]}, 32'(ena_v[r]), 32'(exp_ev.ena[r]));
        chk({"dir_", nm[r]}, 32'(dir_v[r]), 32'(m_dir[r]));
        chk({"err_", nm[r]}, 32'(err_v[r]), 32'(exp_ev.err));
        chk({"sticky_", nm[r]}, 32'(es_v[r]), 32'(m_sticky));
        chk({"ab_q_", nm[r]}, 32'(ab_v[r]), 32'(m_filt));
      end
    end
    for (int r = 0; r < 3; r++) n_ena[r] += int'(ena_v[r]);
    n_err += int'(err_v[0]);
`ifdef QDEC_INDEX_EN
    n_idx += int'(idx_v[0]) + int'(idx_v[1]) + int'(idx_v[2]);
`endif
    if (ena_v[0] && first_ena < 0) first_ena = cyc;
    cyc++;
  endtask

  task automatic drive(input logic [1:0] ab, input int n);
    {a_in, b_in} = ab;
    repeat (n) tick();
  endtask

  task automatic clear_counts();
    for (int r = 0; r < 3; r++) n_ena[r] = 0;
    n_err = 0;
    n_idx = 0;
    first_ena = -1;
  endtask

  // DUT is known settled in RUN at a reset-like state with inputs at v.
  task automatic model_sync(input logic [1:0] v);
    m_filt   = v;
    d1       = '0;
    d2       = '0;
    m_dir    = 3'b111;
    m_sticky = 1'b0;
    model_on = 1'b1;
  endtask

  initial begin
    int k0, p, d, delta;
    aclr = 1'b1; sclr = 1'b0; a_in = 1'b0; b_in = 1'b0;
`ifdef QDEC_INDEX_EN
    z_in = 1'b0;
`endif
    clear_counts();
    tick(); tick();
    for (int r = 0; r < 3; r++) begin
      chk({"rst_ena_", nm[r]}, 32'(ena_v[r]), 32'd0);
      chk({"rst_dir_", nm[r]}, 32'(dir_v[r]), 32'd1);
      chk({"rst_err_", nm[r]}, 32'(err_v[r]), 32'd0);
      chk({"rst_sticky_", nm[r]}, 32'(es_v[r]), 32'd0);
      chk({"rst_ab_", nm[r]}, 32'(ab_v[r]), 32'd0);
    end
    aclr = 1'b0;
    drive(2'b00, 20);
    model_sync(2'b00);

    // Forward rotation
    clear_counts();
    k0 = cyc;
    drive(2'b10, 10); drive(2'b11, 10); drive(2'b01, 10); drive(2'b00, 10);
    chk("fwd_cnt_x4", 32'(n_ena[0]), 32'd4);
    chk("fwd_cnt_x2", 32'(n_ena[1]), 32'd2);
    chk("fwd_cnt_x1", 32'(n_ena[2]), 32'd1);
    chk("fwd_latency", 32'(first_ena - k0), 32'd6);
    chk("fwd_dir", 32'(dir_v[0]), 32'd1);
    chk("fwd_no_err", 32'(n_err), 32'd0);

    // Reverse rotation
    clear_counts();
    drive(2'b01, 10); drive(2'b11, 10); drive(2'b10, 10); drive(2'b00, 10);
    chk("rev_cnt_x4", 32'(n_ena[0]), 32'd4);
    chk("rev_cnt_x2", 32'(n_ena[1]), 32'd2);
    chk("rev_cnt_x1", 32'(n_ena[2]), 32'd1);
    chk("rev_dir_x4", 32'(dir_v[0]), 32'd0);
    chk("rev_dir_x1", 32'(dir_v[2]), 32'd0);

    // Glitch filter: 2-cycle pulse rejected, 3-cycle pulse accepted
    clear_counts();
    drive(2'b10, 2); drive(2'b00, 12);
    chk("glitch2_ena", 32'(n_ena[0]), 32'd0);
    chk("glitch2_ab", 32'(ab_v[0]), 32'd0);
    clear_counts();
    drive(2'b10, 3); drive(2'b00, 4);
    chk("glitch3_ab", 32'(ab_v[0]), 32'h2);
    chk("glitch3_ena", 32'(n_ena[0]), 32'd1);
    chk("glitch3_dir", 32'(dir_v[0]), 32'd1);
    drive(2'b00, 10);

    // Illegal double transition
    clear_counts();
    drive(2'b11, 15);
    chk("ill_err_pulses", 32'(n_err), 32'd1);
    chk("ill_ena", 32'(n_ena[0]), 32'd0);
    chk("ill_sticky", 32'(es_v[0]), 32'd1);

    // Synchronous clear, then re-arm with inputs at 11
    model_on = 1'b0;
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    chk("sclr_sticky", 32'(es_v[0]), 32'd0);
    chk("sclr_ab", 32'(ab_v[0]), 32'd0);
    clear_counts();
    drive(2'b11, 20);
    chk("sclr_init_ena", 32'(n_ena[0]), 32'd0);
    chk("sclr_init_err", 32'(n_err), 32'd0);
    model_sync(2'b11);
    clear_counts();
    drive(2'b01, 10);
    chk("sclr_step_ena", 32'(n_ena[0]), 32'd1);
    chk("sclr_step_dir", 32'(dir_v[0]), 32'd1);

    // Set sticky and dir=0, then aclr mid-step
    drive(2'b10, 10);
    drive(2'b00, 10);
    chk("pre_sticky", 32'(es_v[0]), 32'd1);
    chk("pre_dir", 32'(dir_v[0]), 32'd0);
    drive(2'b01, 5);
    chk("pre_ab", 32'(ab_v[0]), 32'h1);
    model_on = 1'b0;
    aclr = 1'b1;
    #1;
    chk("aclr_ena", 32'(ena_v[0]), 32'd0);
    chk("aclr_dir", 32'(dir_v[0]), 32'd1);
    chk("aclr_err", 32'(err_v[0]), 32'd0);
    chk("aclr_sticky", 32'(es_v[0]), 32'd0);
    chk("aclr_ab", 32'(ab_v[0]), 32'd0);

    // Reset released with both inputs high
    clear_counts();
    drive(2'b11, 3);
    aclr = 1'b0;
    drive(2'b11, 20);
    chk("rsthi_err", 32'(n_err), 32'd0);
    chk("rsthi_ena", 32'(n_ena[0]), 32'd0);
    model_sync(2'b11);
    clear_counts();
    drive(2'b01, 10);
    chk("rsthi_step_ena", 32'(n_ena[0]), 32'd1);
    chk("rsthi_step_dir", 32'(dir_v[0]), 32'd1);

    // Randomized walk: legal steps, reversals, double flips, short holds
    p = 3;
    for (int seg = 0; seg < 400; seg++) begin
      d = int'($urandom_range(0, 9));
      delta = (d < 4) ? 1 : (d < 8) ? 3 : 2;
      p = (p + delta) % 4;
      drive(ab_of(p), int'($urandom_range(1, 8)));
    end
    drive(ab_of(p), 12);

`ifdef QDEC_INDEX_EN
    // Index channel
    clear_counts();
    z_in = 1'b1; repeat (5) tick();
    z_in = 1'b0; repeat (10) tick();
    chk("idx_5cyc", 32'(n_idx), 32'd3);
    clear_counts();
    z_in = 1'b1; repeat (2) tick();
    z_in = 1'b0; repeat (10) tick();
    chk("idx_2cyc", 32'(n_idx), 32'd0);
    model_on = 1'b0;
    aclr = 1'b1;
    z_in = 1'b1;
    repeat (3) tick();
    aclr = 1'b0;
    clear_counts();
    repeat (20) tick();
    chk("idx_init", 32'(n_idx), 32'd0);
    z_in = 1'b0; repeat (10) tick();
    clear_counts();
    z_in = 1'b1; repeat (5) tick();
    z_in = 1'b0; repeat (5) tick();
    chk("idx_after_init", 32'(n_idx), 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
